// File: rtl/hold_ctrl.sv
// rtl/hold_ctrl.sv - pipeline hold/flush controller for bus, MDU, jump and load-use hazards
module hold_ctrl #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_is_load_i,
  input  logic [4:0]  ex_w_reg_addr_i,
  input  logic [4:0]  id_r_reg_addr_1_i,
  input  logic [4:0]  id_r_reg_addr_2_i,
  input  logic        id_r_reg_en_1_i,
  input  logic        id_r_reg_en_2_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        mdu_start_i,
  input  logic        mdu_done_i,
  input  logic        bus_req_i,
  input  logic        bus_ack_i,
  output logic        pc_hold_o,
  output logic        pc_jump_o,
  output logic [31:0] pc_jump_addr_o,
  output logic [1:0]  hold_if_id_o,
  output logic [1:0]  hold_id_ex_o,
  output logic [1:0]  hold_ex_mem_o,
  output logic [1:0]  hold_mem_wb_o,
  output logic        bus_err_o,
  output logic [31:0] stall_cnt_o
);

  typedef logic [1:0] holdpip_bus;
  localparam holdpip_bus hold_none  = 2'b00;
  localparam holdpip_bus hold_wait  = 2'b01;
  localparam holdpip_bus hold_flush = 2'b10;

  localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BUS_WAIT = 2'b01,
    MDU_BUSY = 2'b10
  } state_t;

  state_t      state, state_n;
  logic [7:0]  tmo_cnt, tmo_cnt_n;
  logic        bus_tmo;
  logic        bus_stall;
  logic        mdu_stall;
  logic        load_use;
  logic        in_idle;
  logic        hold_raw;

  assign in_idle = (state == IDLE);

  // A timeout cycle is not a stall: holds drop while the error pulses.
  assign bus_tmo   = (state == BUS_WAIT) && !bus_ack_i && (tmo_cnt == TMO_LAST);
  assign bus_stall = (in_idle && bus_req_i && !bus_ack_i) ||
                     ((state == BUS_WAIT) && !bus_ack_i && !bus_tmo);
  assign mdu_stall = (in_idle && mdu_start_i && !mdu_done_i) ||
                     ((state == MDU_BUSY) && !mdu_done_i);

  assign load_use = ex_is_load_i && (ex_w_reg_addr_i != 5'd0) &&
                    ((id_r_reg_en_1_i && (id_r_reg_addr_1_i == ex_w_reg_addr_i)) ||
                     (id_r_reg_en_2_i && (id_r_reg_addr_2_i == ex_w_reg_addr_i)));

  assign hold_raw = bus_stall || mdu_stall || (in_idle && !jump_flag_i && load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= 8'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      state   <= state_n;
      tmo_cnt <= tmo_cnt_n;
      if (hold_raw) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    tmo_cnt_n = 8'd0;
    case (state)
      IDLE: begin
        if (bus_stall) begin
          state_n = BUS_WAIT;
        end else if (mdu_stall) begin
          state_n = MDU_BUSY;
        end
      end
      BUS_WAIT: begin
        if (bus_ack_i || bus_tmo) begin
          state_n = IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + 8'd1;
        end
      end
      MDU_BUSY: begin
        if (mdu_done_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of inputs.
  always_comb begin
    pc_hold_o      = 1'b0;
    pc_jump_o      = 1'b0;
    pc_jump_addr_o = 32'd0;
    hold_if_id_o   = hold_none;
    hold_id_ex_o   = hold_none;
    hold_ex_mem_o  = hold_none;
    hold_mem_wb_o  = hold_none;
    bus_err_o      = 1'b0;
    if (rst_n) begin
      if (bus_stall) begin
        pc_hold_o     = 1'b1;
        hold_if_id_o  = hold_wait;
        hold_id_ex_o  = hold_wait;
        hold_ex_mem_o = hold_wait;
        hold_mem_wb_o = hold_wait;
      end else if (bus_tmo) begin
        bus_err_o = 1'b1;
      end else if (mdu_stall) begin
        pc_hold_o     = 1'b1;
        hold_if_id_o  = hold_wait;
        hold_id_ex_o  = hold_wait;
        hold_ex_mem_o = hold_flush;
      end else if (in_idle && jump_flag_i) begin
        pc_jump_o      = 1'b1;
        pc_jump_addr_o = jump_addr_i;
        hold_if_id_o   = hold_flush;
        hold_id_ex_o   = hold_flush;
      end else if (in_idle && load_use) begin
        pc_hold_o    = 1'b1;
        hold_if_id_o = hold_wait;
        hold_id_ex_o = hold_flush;
      end
    end
  end

endmodule
